sfp_accum: RTL and testbench

Multi-tap output accumulator and activation stage between the last row of the MAC array and the output FIFO. For each of COL columns it holds DEPTH accumulation entries, one per output pixel of the current tile, and sums num_taps passes of partial sums into them with independent per-column write pointers to absorb systolic skew. When every column has finished, it drains the tile one entry per handshake, applying optional ReLU and saturation.

---
 rtl/sfp_pkg.sv | 30 +++
 rtl/sfp_act_sat.sv | 22 ++
 rtl/sfp_accum.sv | 133 +++++++++++++
 tb/tb_sfp_accum.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared types, widths and arithmetic helpers for the sfp_accum output stage.
package sfp_pkg;

    localparam int unsigned SFP_COL     = 8;
    localparam int unsigned SFP_PSUM_BW = 16;
    localparam int unsigned SFP_ACC_BW  = 20;
    localparam int unsigned SFP_DEPTH   = 16;
    localparam int unsigned SFP_TAP_BW  = 4;

    localparam logic signed [SFP_ACC_BW-1:0] SFP_SAT_MAX = SFP_ACC_BW'(2**(SFP_PSUM_BW-1) - 1);
    localparam logic signed [SFP_ACC_BW-1:0] SFP_SAT_MIN = ~SFP_SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [SFP_ACC_BW-1:0] sign_ext(input logic [SFP_PSUM_BW-1:0] x);
        return SFP_ACC_BW'($signed(x));
    endfunction

    // Clamp a two's-complement accumulator value into the output lane range.
    function automatic logic [SFP_PSUM_BW-1:0] sat_psum(input logic [SFP_ACC_BW-1:0] v);
        if ($signed(v) > SFP_SAT_MAX) return {1'b0, {(SFP_PSUM_BW-1){1'b1}}};
        if ($signed(v) < SFP_SAT_MIN) return {1'b1, {(SFP_PSUM_BW-1){1'b0}}};
        return v[SFP_PSUM_BW-1:0];
    endfunction

endpackage

// File: rtl/sfp_act_sat.sv
// One output lane: optional ReLU, then saturate or truncate to the lane width.
module sfp_act_sat
    import sfp_pkg::*;
#(
    parameter int unsigned ACC_BW  = SFP_ACC_BW,
    parameter int unsigned PSUM_BW = SFP_PSUM_BW
) (
    input  logic [ACC_BW-1:0]  acc,
    input  logic               relu_en,
    input  logic               sat_en,
    output logic [PSUM_BW-1:0] res_c
);

    logic [ACC_BW-1:0] relu_c;

    always_comb begin
        relu_c = acc;
        if (relu_en && acc[ACC_BW-1]) relu_c = '0;
        res_c = sat_en ? sat_psum(relu_c) : relu_c[PSUM_BW-1:0];
    end

endmodule

// File: rtl/sfp_accum.sv
// Multi-tap per-column psum accumulator with a ReLU/saturate drain stage.
module sfp_accum
    import sfp_pkg::*;
#(
    parameter int unsigned COL     = SFP_COL,
    parameter int unsigned PSUM_BW = SFP_PSUM_BW,
    parameter int unsigned ACC_BW  = SFP_ACC_BW,
    parameter int unsigned DEPTH   = SFP_DEPTH,
    parameter int unsigned TAP_BW  = SFP_TAP_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TAP_BW-1:0]      num_taps,
    input  logic                   relu_en,
    input  logic                   sat_en,
    input  logic [PSUM_BW*COL-1:0] in_psum,
    input  logic [COL-1:0]         valid_in,
    output logic [PSUM_BW*COL-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e                   state_q, state_d;
    logic [TAP_BW-1:0]        taps_q;
    logic                     relu_q, sat_q;
    logic [AW-1:0]            rd_ptr_q;
    logic [AW-1:0]            rd_sel_c;
    logic [COL-1:0]           fin_c;
    logic [PSUM_BW*COL-1:0]   lanes_c;
    logic                     start_ok_c, drain_enter_c, hs_c, last_hs_c, load_c, err_hit_c;

    assign start_ok_c    = (state_q == ST_IDLE) && start;
    assign drain_enter_c = (state_q == ST_ACCUM) && (&fin_c);
    assign hs_c          = out_valid && out_ready;
    assign last_hs_c     = hs_c && (rd_ptr_q == AW'(DEPTH-1));
    assign load_c        = drain_enter_c || (hs_c && !last_hs_c);
    assign err_hit_c     = (state_q == ST_ACCUM) && (|(valid_in & fin_c));
    // Pre-select the entry that the output register will hold after this edge.
    assign rd_sel_c      = (state_q == ST_DRAIN) ? rd_ptr_q + AW'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)         state_d = ST_ACCUM;
            ST_ACCUM: if (drain_enter_c) state_d = ST_DRAIN;
            ST_DRAIN: if (last_hs_c)     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Per-column write pointer, tap counter and entry storage.
    for (genvar k = 0; k < COL; k++) begin : g_col
        logic [AW-1:0]      addr_q;
        logic [TAP_BW-1:0]  tap_q;
        logic [ACC_BW-1:0]  entry_q [DEPTH];
        logic [PSUM_BW-1:0] lane_c;
        logic               wr_c;

        assign lane_c   = in_psum[k*PSUM_BW +: PSUM_BW];
        assign fin_c[k] = (tap_q == taps_q);
        assign wr_c     = (state_q == ST_ACCUM) && valid_in[k] && !fin_c[k];

        always_ff @(posedge clk) begin
            if (reset) begin
                addr_q <= '0;
                tap_q  <= '0;
                for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
            end else if (start_ok_c) begin
                addr_q <= '0;
                tap_q  <= '0;
            end else if (wr_c) begin
                // First tap overwrites stale data from the previous tile.
                entry_q[addr_q] <= (tap_q == '0) ? sign_ext(lane_c)
                                                 : entry_q[addr_q] + sign_ext(lane_c);
                addr_q <= addr_q + AW'(1);
                if (addr_q == AW'(DEPTH-1)) tap_q <= tap_q + TAP_BW'(1);
            end
        end

        sfp_act_sat #(.ACC_BW(ACC_BW), .PSUM_BW(PSUM_BW)) u_act (
            .acc     (entry_q[rd_sel_c]),
            .relu_en (relu_q),
            .sat_en  (sat_q),
            .res_c   (lanes_c[k*PSUM_BW +: PSUM_BW])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taps_q    <= '0;
            relu_q    <= 1'b0;
            sat_q     <= 1'b0;
            rd_ptr_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= last_hs_c;
            if (start_ok_c) begin
                taps_q   <= (num_taps == '0) ? TAP_BW'(1) : num_taps;
                relu_q   <= relu_en;
                sat_q    <= sat_en;
                rd_ptr_q <= '0;
                err      <= 1'b0;
            end else if (err_hit_c) begin
                err <= 1'b1;
            end
            if (hs_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= lanes_c;
            end else if (last_hs_c) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sfp_accum.sv
// Directed scoreboard bench for sfp_accum (COL=8, PSUM_BW=16, ACC_BW=20, DEPTH=4).
module tb_sfp_accum;

    localparam int unsigned COL = 8;
    localparam int unsigned PW  = 16;
    localparam int unsigned DW  = COL * PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    num_taps;
    logic          relu_en, sat_en;
    logic [DW-1:0] in_psum;
    logic [COL-1:0] valid_in;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, busy, done, err;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    logic [DW-1:0] sb [$];

    sfp_accum #(.COL(8), .PSUM_BW(16), .ACC_BW(20), .DEPTH(4), .TAP_BW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .num_taps(num_taps),
        .relu_en(relu_en), .sat_en(sat_en), .in_psum(in_psum), .valid_in(valid_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted entry is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL drain_unexpected: got %h want none", out_data);
            end else begin
                check_vec("drain_data", out_data, sb.pop_front());
            end
        end
        if (!out_valid) check_vec("idle_data_zero", out_data, '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [3:0] taps, input logic relu, input logic sat);
        start = 1'b1; num_taps = taps; relu_en = relu; sat_en = sat;
        tick();
        start = 1'b0;
        check_bit("start_busy", busy, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check_bit({name, "_drain_entry"}, out_valid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        out_ready = 1'b0;
        check_bit({name, "_done"}, seen, 1'b1);
        check_bit({name, "_busy_low"}, busy, 1'b0);
        check_int({name, "_sb_empty"}, sb.size(), 0);
    endtask

    function automatic logic [DW-1:0] uniform(input logic [PW-1:0] v);
        logic [DW-1:0] e;
        for (int k = 0; k < int'(COL); k++) e[k*PW +: PW] = v;
        return e;
    endfunction

    task automatic run_tap2(input logic relu, input logic sat,
                            input logic [PW-1:0] e0, input logic [PW-1:0] e1, input logic [PW-1:0] e2);
        logic [DW-1:0] e;
        start_tile(4'd2, relu, sat);
        in_psum = uniform(16'd1);
        in_psum[0*PW +: PW] = 16'hFFFB;
        in_psum[1*PW +: PW] = 16'h7530;
        in_psum[2*PW +: PW] = 16'hB1E0;
        valid_in = '1;
        for (int i = 0; i < 8; i++) tick();
        valid_in = '0;
        e = uniform(16'd2);
        e[0*PW +: PW] = e0;
        e[1*PW +: PW] = e1;
        e[2*PW +: PW] = e2;
        for (int i = 0; i < 4; i++) sb.push_back(e);
        wait_valid("relu_sat");
        wait_done("relu_sat");
    endtask

    initial begin
        logic [DW-1:0] e;
        int hs_base;
        reset = 1'b1; start = 1'b0; num_taps = '0; relu_en = 1'b0; sat_en = 1'b0;
        in_psum = '0; valid_in = '0; out_ready = 1'b0;
        tick(); tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_valid", out_valid, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_vec("rst_data", out_data, '0);
        reset = 1'b0;
        tick();

        // 1: single tap, aligned columns
        start_tile(4'd1, 1'b0, 1'b0);
        for (int k = 0; k < int'(COL); k++) in_psum[k*PW +: PW] = PW'(k + 1);
        valid_in = '1;
        for (int i = 0; i < 4; i++) tick();
        valid_in = '0;
        for (int i = 0; i < 4; i++) sb.push_back(in_psum);
        check_bit("t1_not_yet_drain", out_valid, 1'b0);
        tick();
        check_bit("t1_drain_next_cycle", out_valid, 1'b1);
        wait_done("t1");
        tick();
        check_bit("t1_done_pulse", done, 1'b0);

        // 2: three taps, column k skewed by k cycles
        start_tile(4'd3, 1'b0, 1'b0);
        in_psum = uniform(16'd100);
        for (int i = 0; i < 19; i++) begin
            for (int k = 0; k < int'(COL); k++) valid_in[k] = (i >= k) && (i < k + 12);
            tick();
        end
        valid_in = '0;
        for (int i = 0; i < 4; i++) sb.push_back(uniform(16'd300));
        check_bit("t2_pre_drain", out_valid, 1'b0);
        tick();
        check_bit("t2_drain_start", out_valid, 1'b1);
        check_vec("t2_entry0", out_data, uniform(16'd300));
        wait_done("t2");
        check_bit("t2_err", err, 1'b0);

        // 3: ReLU / saturate / truncate combinations
        run_tap2(1'b1, 1'b1, 16'h0000, 16'h7FFF, 16'h0000);
        run_tap2(1'b1, 1'b0, 16'h0000, 16'hEA60, 16'h0000);
        run_tap2(1'b0, 1'b1, 16'hFFF6, 16'h7FFF, 16'h8000);
        run_tap2(1'b0, 1'b0, 16'hFFF6, 16'hEA60, 16'h63C0);

        // 4: backpressure
        start_tile(4'd1, 1'b0, 1'b0);
        valid_in = '1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < int'(COL); k++) in_psum[k*PW +: PW] = PW'(16*i + k);
            sb.push_back(in_psum);
            tick();
        end
        valid_in = '0;
        e = sb[0];
        wait_valid("t4");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec("t4_hold_data", out_data, e);
            check_bit("t4_hold_valid", out_valid, 1'b1);
        end
        hs_base = hs_count;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            tick();
            check_bit("t4_done_timing", done, i == 6);
            if (i == 6) begin
                check_bit("t4_valid_after", out_valid, 1'b0);
                check_bit("t4_busy_after", busy, 1'b0);
            end
        end
        out_ready = 1'b0;
        check_int("t4_handshakes", hs_count - hs_base, 4);

        // 5: overflow error and start while busy
        start_tile(4'd1, 1'b0, 1'b0);
        in_psum = '0;
        in_psum[3*PW +: PW] = 16'd7;
        valid_in = 8'b0000_1000;
        for (int i = 0; i < 4; i++) tick();
        in_psum[3*PW +: PW] = 16'd999;
        check_bit("t5_err_before", err, 1'b0);
        tick();
        check_bit("t5_err_set", err, 1'b1);
        valid_in = '0;
        start = 1'b1; num_taps = 4'd5;
        tick();
        start = 1'b0;
        check_bit("t5_busy_kept", busy, 1'b1);
        check_bit("t5_err_kept", err, 1'b1);
        for (int k = 0; k < int'(COL); k++) in_psum[k*PW +: PW] = PW'(10*k + 1);
        valid_in = 8'b1111_0111;
        for (int i = 0; i < 4; i++) tick();
        valid_in = '0;
        e = in_psum;
        e[3*PW +: PW] = 16'd7;
        for (int i = 0; i < 4; i++) sb.push_back(e);
        wait_valid("t5");
        wait_done("t5");
        check_bit("t5_err_sticky", err, 1'b1);

        // 6: reset mid-drain, zero taps, back-to-back start
        start_tile(4'd1, 1'b0, 1'b0);
        check_bit("t6_err_cleared", err, 1'b0);
        for (int k = 0; k < int'(COL); k++) in_psum[k*PW +: PW] = PW'(200 + k);
        valid_in = '1;
        for (int i = 0; i < 4; i++) tick();
        valid_in = '0;
        for (int i = 0; i < 4; i++) sb.push_back(in_psum);
        wait_valid("t6");
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        check_bit("t6_rst_busy", busy, 1'b0);
        check_bit("t6_rst_valid", out_valid, 1'b0);
        check_vec("t6_rst_data", out_data, '0);
        check_bit("t6_rst_done", done, 1'b0);
        reset = 1'b0;
        check_int("t6_two_accepted", sb.size(), 2);
        sb.delete();
        tick();
        check_bit("t6_no_done", done, 1'b0);

        start_tile(4'd0, 1'b0, 1'b0);
        for (int k = 0; k < int'(COL); k++) in_psum[k*PW +: PW] = PW'(50 + k);
        valid_in = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("t6_zero_tap_accum", out_valid, 1'b0);
        end
        tick();
        valid_in = '0;
        for (int i = 0; i < 4; i++) sb.push_back(in_psum);
        tick();
        check_bit("t6_zero_tap_drain", out_valid, 1'b1);
        wait_done("t6z");
        start = 1'b1; num_taps = 4'd1;
        tick();
        start = 1'b0;
        check_bit("t6_b2b_busy", busy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
